// File: rtl/pc_stack_unit.sv
// pc_stack_unit
// Program-counter sequencer with a hardware return-address stack.
// Each cycle it drives the fetch address and picks exactly one action,
// in priority ret > call > jump > increment. Stack overflow or underflow
// parks the unit in HALT with a sticky fault code until reset.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   stall       hold all state this cycle
//   jump        load jump_addr
//   call        push return address, load jump_addr
//   ret         pop stack top into instr_addr
//   jump_addr   target for jump/call
//   instr_addr  current fetch address (registered)
//   sp          number of valid stack entries
//   top         stack[sp-1], 0 when the stack is empty
//   halted      1 while in HALT
//   fault       00 none, 01 overflow, 10 underflow (sticky)
module pc_stack_unit #(
  parameter int              ADDR_W     = 16,
  parameter int              DEPTH      = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int             SP_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [SP_W-1:0]   sp,
  output logic [ADDR_W-1:0] top,
  output logic              halted,
  output logic [1:0]        fault
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0]      FAULT_NONE  = 2'b00;
  localparam logic [1:0]      FAULT_OVER  = 2'b01;
  localparam logic [1:0]      FAULT_UNDER = 2'b10;
  localparam logic [SP_W-1:0] SP_FULL     = SP_W'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [ADDR_W-1:0] next_seq;
  logic              stack_full;
  logic              stack_empty;
  logic              active;
  logic              push_en;

  assign next_seq    = instr_addr + ADDR_W'(1);
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign active      = (state == RUN) && !stall && !reset;

  // A push happens only when call wins arbitration (no ret) and there is room.
  assign push_en = active && !ret && call && !stack_full;

  // Top-of-stack is decoded from registers only: select the entry whose
  // index is sp-1, or zero when nothing has been pushed.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) top = stack_mem[i];
    end
  end

  // Stack storage is not reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_en && (sp == SP_W'(i))) stack_mem[i] <= next_seq;
    end
  end

  // Control FSM: RUN arbitrates one action per unstalled edge, HALT holds
  // everything until reset. Fault detection only happens in an active cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      instr_addr <= RESET_ADDR;
      sp         <= '0;
      halted     <= 1'b0;
      fault      <= FAULT_NONE;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (ret) begin
              if (stack_empty) begin
                state  <= HALT;
                halted <= 1'b1;
                fault  <= FAULT_UNDER;
              end else begin
                instr_addr <= top;
                sp         <= sp - SP_W'(1);
              end
            end else if (call) begin
              if (stack_full) begin
                state  <= HALT;
                halted <= 1'b1;
                fault  <= FAULT_OVER;
              end else begin
                instr_addr <= jump_addr;
                sp         <= sp + SP_W'(1);
              end
            end else if (jump) begin
              instr_addr <= jump_addr;
            end else begin
              instr_addr <= next_seq;
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter sequencer with a hardware return-address stack, successor to the fixed 16-bit counter. It adds call/return, stall, configurable address width and stack depth, and a fault/halt state machine. It sits between the instruction decoder/jump logic and program memory, and drives the fetch address every cycle.

## Interface
- ADDR_W, 16: width of instruction address and stack entries (≥ 2).
- DEPTH, 8: number of return-stack entries (≥ 1).
- RESET_ADDR, 0: value loaded into instr_addr on reset (ADDR_W bits).
- SP_W, $clog2(DEPTH+1): width of sp output (localparam, not overridable).

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- stall  in  1  hold all state this cycle.
- jump  in  1  load jump_addr.
- call  in  1  push return address, load jump_addr.
- ret  in  1  pop stack top into instr_addr.
- jump_addr  in  ADDR_W  target for jump/call.
- instr_addr  out  ADDR_W  current fetch address (registered).
- sp  out  SP_W  number of valid stack entries.
- top  out  ADDR_W  stack[sp-1]; 0 when sp==0.
- halted  out  1  1 in HALT state.
- fault  out  2  00 none, 01 overflow, 10 underflow; sticky until reset.

## Operation
- Two states: RUN, HALT. Reset → RUN.
- Reset values: instr_addr=RESET_ADDR, sp=0, halted=0, fault=00, top=0. Stack contents are not required to be cleared but top must read 0 when sp==0.
- In RUN, on each rising edge with stall=0, one action is taken in priority ret > call > jump > increment:
  - ret, sp>0: instr_addr ← stack[sp-1]; sp ← sp-1.
  - ret, sp==0: underflow; → HALT, fault=10, instr_addr and sp unchanged.
  - call, sp<DEPTH: stack[sp] ← (instr_addr+1) mod 2^ADDR_W; sp ← sp+1; instr_addr ← jump_addr.
  - call, sp==DEPTH: overflow; → HALT, fault=01, no push, instr_addr unchanged.
  - jump: instr_addr ← jump_addr; sp unchanged.
  - none: instr_addr ← (instr_addr+1) mod 2^ADDR_W (wraps all-ones → 0).
- Lower-priority requests asserted with a higher one are ignored, not queued. For example, with call+ret together, only ret is performed; with call+jump together, only call is performed (both use jump_addr).
- stall=1 in RUN: instr_addr, sp, stack, state all hold; no fault detection that cycle.
- HALT: all inputs except reset are ignored; instr_addr, sp, stack hold; halted=1. Only reset leaves HALT.
- Arithmetic: increment and return address are ADDR_W-bit modulo; sp never exceeds DEPTH or goes below 0.

## Timing
- Inputs are sampled at the rising edge; the new instr_addr, sp, top, halted and fault are visible after that same edge, so latency is 1 cycle.
- Combinational path from inputs to outputs is not permitted; all outputs come from registers or from register-only decode (top).
- Push and pop complete in a single cycle; back-to-back call/call, call/ret and ret/ret on consecutive cycles are supported with no bubble.
- Reset asserted mid-operation (including during stall or in HALT) forces the reset values immediately, without waiting for an edge. Operation resumes on the first rising edge after deassertion, and the first action taken is from RESET_ADDR.
- Faults take effect on the edge that detects them: halted=1 and fault are valid in the following cycle.

## Test plan
- Reset/increment: ADDR_W=16, RESET_ADDR=0, assert reset mid-run at instr_addr=0x0005 → instr_addr=0 immediately; 4 idle edges after release → 1,2,3,4.
- Wrap: jump to 0xFFFE, then 2 idle edges → 0xFFFF, 0x0000; call at 0xFFFF with jump_addr=0x10 → pushed top=0x0000, instr_addr=0x10.
- Nested call/return: DEPTH=8; from 0x20 call 0x100, from 0x100 call 0x200, ret, ret → instr_addr sequence 0x100, 0x200, 0x101, 0x21; sp 1,2,1,0; top 0x21,0x101,0x21,0.
- Overflow: 8 calls fill the stack (sp=8); 9th call → halted=1, fault=01, instr_addr and sp unchanged; later jump/ret ignored until reset.
- Underflow and priority: ret at sp=0 → fault=10, halted=1. After reset, call+ret together at sp=1 → only pop performed, sp=0.
- Stall: stall=1 for 3 cycles with call asserted → no change to instr_addr, sp or top; on release, one call executes.
